// File: rtl/alu_result_display.sv
// alu_result_display: captures an 8-bit ALU result, converts it to decimal
// with a sequential shift-add-3 engine, then cycles the digits (with a
// leading minus for negative signed values) on one seven-segment display,
// followed by a blank gap, until the next load.
module alu_result_display #(
   parameter int unsigned DWELL_CYCLES = 10_000_000,
   parameter int unsigned DWELL_W      = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] result,
   input  logic       is_signed,
   input  logic       load,
   output logic [6:0] seg,
   output logic       dp,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_SHOW = 2'd2
   } state_t;

   // Symbol slots in display order; slot 4 (blank) closes every pass.
   localparam logic [2:0] SLOT_MINUS = 3'd0;
   localparam logic [2:0] SLOT_HUND  = 3'd1;
   localparam logic [2:0] SLOT_TENS  = 3'd2;
   localparam logic [2:0] SLOT_ONES  = 3'd3;
   localparam logic [2:0] SLOT_BLANK = 3'd4;

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
   localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

   // Seven-segment pattern for a BCD digit; non-decimal codes show blank.
   function automatic logic [6:0] digit_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // Double-dabble correction of one BCD nibble before a shift.
   function automatic logic [3:0] add3(input logic [3:0] n);
      logic [3:0] r;
      if (n >= 4'd5) begin
         r = n + 4'd3;
      end else begin
         r = n;
      end
      return r;
   endfunction

   // Next slot to show after 'cur'; leading zeros and a positive sign are skipped.
   function automatic logic [2:0] next_slot(input logic [2:0] cur, input logic neg,
                                            input logic has_h, input logic has_t);
      logic [2:0] n;
      case (cur)
         SLOT_MINUS: n = has_h ? SLOT_HUND : (has_t ? SLOT_TENS : SLOT_ONES);
         SLOT_HUND:  n = SLOT_TENS;
         SLOT_TENS:  n = SLOT_ONES;
         SLOT_ONES:  n = SLOT_BLANK;
         SLOT_BLANK: n = neg ? SLOT_MINUS :
                         (has_h ? SLOT_HUND : (has_t ? SLOT_TENS : SLOT_ONES));
         default:    n = SLOT_BLANK;
      endcase
      return n;
   endfunction

   state_t             state_q, state_d;
   logic               neg_q, neg_d;
   // {hundreds, tens, ones, magnitude} shift register for the conversion
   logic [19:0]        sr_q, sr_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [2:0]         slot_q, slot_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [6:0]         seg_q, seg_d;
   logic               dp_q, dp_d;
   logic               busy_q, busy_d;

   logic               ld_neg;
   logic [7:0]         ld_mag;
   logic [19:0]        sr_adj;
   logic               has_h, has_t;
   logic [2:0]         nxt_slot;
   logic [6:0]         nxt_seg;

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d  = state_q;
      neg_d    = neg_q;
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      slot_d   = slot_q;
      dwell_d  = dwell_q;
      seg_d    = seg_q;
      dp_d     = dp_q;
      busy_d   = busy_q;

      ld_neg   = is_signed & result[7];
      ld_mag   = ld_neg ? (~result + 8'd1) : result;
      sr_adj   = {add3(sr_q[19:16]), add3(sr_q[15:12]), add3(sr_q[11:8]), sr_q[7:0]};
      has_h    = (sr_q[19:16] != 4'd0);
      has_t    = has_h | (sr_q[15:12] != 4'd0);
      nxt_slot = next_slot(slot_q, neg_q, has_h, has_t);
      case (nxt_slot)
         SLOT_MINUS: nxt_seg = 7'h40;
         SLOT_HUND:  nxt_seg = digit_seg(sr_q[19:16]);
         SLOT_TENS:  nxt_seg = digit_seg(sr_q[15:12]);
         SLOT_ONES:  nxt_seg = digit_seg(sr_q[11:8]);
         default:    nxt_seg = 7'h00;
      endcase

      if (ena) begin
         if (load) begin
            state_d = ST_CONV;
            neg_d   = ld_neg;
            sr_d    = {12'h000, ld_mag};
            cnt_d   = 3'd0;
            slot_d  = SLOT_BLANK;
            dwell_d = '0;
            seg_d   = 7'h00;
            dp_d    = 1'b0;
            busy_d  = 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  seg_d  = 7'h00;
                  dp_d   = 1'b0;
                  busy_d = 1'b0;
               end
               ST_CONV: begin
                  sr_d  = sr_adj << 1'b1;
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     state_d = ST_SHOW;
                     busy_d  = 1'b0;
                     slot_d  = SLOT_BLANK;
                     dwell_d = '0;
                  end else begin
                     busy_d = 1'b1;
                  end
               end
               ST_SHOW: begin
                  if (dwell_q == '0) begin
                     slot_d  = nxt_slot;
                     seg_d   = nxt_seg;
                     dp_d    = (nxt_slot == SLOT_ONES);
                     dwell_d = DWELL_LAST;
                  end else begin
                     dwell_d = dwell_q - DWELL_ONE;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  seg_d   = 7'h00;
                  dp_d    = 1'b0;
                  busy_d  = 1'b0;
               end
            endcase
         end
      end else begin
         state_d = state_q;
         seg_d   = seg_q;
      end
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         neg_q   <= 1'b0;
         sr_q    <= 20'h00000;
         cnt_q   <= 3'd0;
         slot_q  <= SLOT_MINUS;
         dwell_q <= '0;
         seg_q   <= 7'h00;
         dp_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         neg_q   <= neg_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         slot_q  <= slot_d;
         dwell_q <= dwell_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         busy_q  <= busy_d;
      end
   end

   assign seg  = seg_q;
   assign dp   = dp_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Testbench for alu_result_display with a short dwell; expected waveforms
// come from a decimal model of the value and a timeline relative to the load.
module tb_alu_result_display;

   localparam int DW = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] result = 8'h00;
   logic       is_signed = 1'b0;
   logic       load = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;

   logic [6:0] dig_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   logic [6:0] exp_seg [$];
   logic       exp_dp  [$];
   logic [8:0] obs     [$];   // {busy, dp, seg} sampled after each edge

   alu_result_display #(.DWELL_CYCLES(DW), .DWELL_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .result(result),
      .is_signed(is_signed), .load(load), .seg(seg), .dp(dp), .busy(busy)
   );

   always #5 clk = ~clk;

   // Build the symbol list of a value from its decimal representation.
   function automatic void build_list(input logic [7:0] val, input logic sgn);
      int v, m;
      v = (sgn && val[7]) ? int'(val) - 256 : int'(val);
      m = (v < 0) ? -v : v;
      exp_seg.delete();
      exp_dp.delete();
      if (v < 0) begin exp_seg.push_back(7'h40); exp_dp.push_back(1'b0); end
      if (m >= 100) begin exp_seg.push_back(dig_tab[m / 100]); exp_dp.push_back(1'b0); end
      if (m >= 10) begin exp_seg.push_back(dig_tab[(m / 10) % 10]); exp_dp.push_back(1'b0); end
      exp_seg.push_back(dig_tab[m % 10]); exp_dp.push_back(1'b1);
      exp_seg.push_back(7'h00); exp_dp.push_back(1'b0);
   endfunction

   // Expected {busy,dp,seg} p edges after the load edge (p=0 is just after it).
   function automatic logic [8:0] expected_at(input int p);
      int k;
      if (p < 8) return {1'b1, 1'b0, 7'h00};
      if (p == 8) return 9'h000;
      k = ((p - 9) / DW) % exp_seg.size();
      return {1'b0, exp_dp[k], exp_seg[k]};
   endfunction

   task automatic do_load(input logic [7:0] v, input logic s);
      obs.delete();
      result = v; is_signed = s; load = 1'b1;
      build_list(v, s);
      @(posedge clk); #1;
      load = 1'b0;
      obs.push_back({busy, dp, seg});
   endtask

   task automatic capture(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         obs.push_back({busy, dp, seg});
      end
   endtask

   task automatic test_reset();
      logic [8:0] e;
      rst_n = 1'b0;
      #3;
      vectors++;
      if ({busy, dp, seg} !== 9'h000) begin
         miscompares++; $display("FAIL reset got=%h exp=%h", {busy, dp, seg}, 9'h000);
      end
      @(negedge clk); rst_n = 1'b1;
      obs.delete(); capture(10);
      e = 9'h000;
      for (int i = 0; i < obs.size(); i++) begin
         vectors++;
         if (obs[i] !== e) begin miscompares++; $display("FAIL reset_idle pos=%0d got=%h exp=%h", i, obs[i], e); end
      end
   endtask

   task automatic test_unsigned_123();
      logic [8:0] e;
      do_load(8'h7B, 1'b0);
      capture(8 + 32);
      for (int i = 0; i < obs.size(); i++) begin
         e = expected_at(i); vectors++;
         if (obs[i] !== e) begin miscompares++; $display("FAIL u123 pos=%0d got=%h exp=%h", i, obs[i], e); end
      end
   endtask

   task automatic test_signed();
      logic [8:0] e;
      logic [7:0] vals [3] = '{8'hF6, 8'h80, 8'h80};
      logic       sgns [3] = '{1'b1, 1'b1, 1'b0};
      for (int t = 0; t < 3; t++) begin
         do_load(vals[t], sgns[t]);
         capture(8 + 2 * DW * exp_seg.size());
         for (int i = 0; i < obs.size(); i++) begin
            e = expected_at(i); vectors++;
            if (obs[i] !== e) begin miscompares++; $display("FAIL signed v=%h s=%0d pos=%0d got=%h exp=%h", vals[t], sgns[t], i, obs[i], e); end
         end
      end
   endtask

   task automatic test_zero_single();
      logic [8:0] e;
      logic [7:0] vals [2] = '{8'h00, 8'h07};
      for (int t = 0; t < 2; t++) begin
         do_load(vals[t], 1'b0);
         capture(8 + 3 * DW * exp_seg.size());
         for (int i = 0; i < obs.size(); i++) begin
            e = expected_at(i); vectors++;
            if (obs[i] !== e) begin miscompares++; $display("FAIL small v=%h pos=%0d got=%h exp=%h", vals[t], i, obs[i], e); end
         end
      end
   endtask

   task automatic test_abort();
      logic [8:0] e;
      do_load(8'h7B, 1'b0);
      capture(22);
      for (int i = 0; i < obs.size(); i++) begin
         e = expected_at(i); vectors++;
         if (obs[i] !== e) begin miscompares++; $display("FAIL abort_pre pos=%0d got=%h exp=%h", i, obs[i], e); end
      end
      do_load(8'h2A, 1'b0);
      capture(8 + 24);
      for (int i = 0; i < obs.size(); i++) begin
         e = expected_at(i); vectors++;
         if (obs[i] !== e) begin miscompares++; $display("FAIL abort_post pos=%0d got=%h exp=%h", i, obs[i], e); end
      end
   endtask

   task automatic test_enable();
      logic [8:0] e;
      do_load(8'hF6, 1'b1);
      capture(12);
      for (int i = 0; i < obs.size(); i++) begin
         e = expected_at(i); vectors++;
         if (obs[i] !== e) begin miscompares++; $display("FAIL ena_pre pos=%0d got=%h exp=%h", i, obs[i], e); end
      end
      obs.delete();
      ena = 1'b0; load = 1'b1; result = 8'h55; is_signed = 1'b0;
      capture(10);
      e = expected_at(12);
      for (int i = 0; i < obs.size(); i++) begin
         vectors++;
         if (obs[i] !== e) begin miscompares++; $display("FAIL ena_frozen pos=%0d got=%h exp=%h", i, obs[i], e); end
      end
      ena = 1'b1; load = 1'b0;
      obs.delete();
      capture(20);
      for (int i = 0; i < obs.size(); i++) begin
         e = expected_at(13 + i); vectors++;
         if (obs[i] !== e) begin miscompares++; $display("FAIL ena_resume pos=%0d got=%h exp=%h", i, obs[i], e); end
      end
   endtask

   task automatic test_collision();
      logic [8:0] e;
      do_load(8'h7B, 1'b0);
      capture(16);   // next edge is a dwell expiry
      for (int i = 0; i < obs.size(); i++) begin
         e = expected_at(i); vectors++;
         if (obs[i] !== e) begin miscompares++; $display("FAIL coll_pre pos=%0d got=%h exp=%h", i, obs[i], e); end
      end
      do_load(8'h07, 1'b0);
      capture(8 + 16);
      for (int i = 0; i < obs.size(); i++) begin
         e = expected_at(i); vectors++;
         if (obs[i] !== e) begin miscompares++; $display("FAIL coll_post pos=%0d got=%h exp=%h", i, obs[i], e); end
      end
   endtask

   task automatic test_reset_mid();
      logic [8:0] e;
      do_load(8'h7B, 1'b0);
      capture(14);
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, dp, seg} !== 9'h000) begin
         miscompares++; $display("FAIL reset_mid got=%h exp=%h", {busy, dp, seg}, 9'h000);
      end
      @(negedge clk); rst_n = 1'b1;
      obs.delete(); capture(12);
      e = 9'h000;
      for (int i = 0; i < obs.size(); i++) begin
         vectors++;
         if (obs[i] !== e) begin miscompares++; $display("FAIL reset_mid_idle pos=%0d got=%h exp=%h", i, obs[i], e); end
      end
   endtask

   task automatic test_random();
      logic [8:0] e;
      logic [7:0] v;
      logic       s;
      for (int t = 0; t < 16; t++) begin
         v = 8'($urandom_range(0, 255));
         s = 1'($urandom_range(0, 1));
         do_load(v, s);
         capture(8 + 2 * DW * exp_seg.size());
         for (int i = 0; i < obs.size(); i++) begin
            e = expected_at(i); vectors++;
            if (obs[i] !== e) begin miscompares++; $display("FAIL random v=%h s=%0d pos=%0d got=%h exp=%h", v, s, i, obs[i], e); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_123();
      test_signed();
      test_zero_single();
      test_abort();
      test_enable();
      test_collision();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
